// File: rtl/seq_addsub_381bit.sv
// Multi-cycle 381-bit adder: one SLICE-wide carry-lookahead slice per cycle, valid/ready in and out.
// Optional subtract mode is enabled with `define SEQ_ADDSUB_SUB_EN (adds the op port).
module seq_addsub_381bit #(
  parameter int WIDTH = 381,
  parameter int SLICE = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SEQ_ADDSUB_SUB_EN
  input  logic             op,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  // state | meaning
  // IDLE  | waiting for operands, in_ready=1
  // RUN   | resolving slice k each cycle
  // DONE  | result held, out_valid=1 until out_ready

  localparam int NSLICE = (WIDTH + SLICE - 1) / SLICE;
  localparam int PW     = NSLICE * SLICE;
  localparam int NG     = SLICE / 4;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [KW-1:0]     k;
  logic              carry_reg;
  logic [PW-1:0]     a_sh;
  logic [PW-1:0]     b_sh;
  logic [PW-SLICE-1:0] acc;

  logic [WIDTH-1:0]  b_in;
  logic              c_in;

`ifdef SEQ_ADDSUB_SUB_EN
  assign b_in = op ? ~b : b;
  assign c_in = op | cin;
`else
  assign b_in = b;
  assign c_in = cin;
`endif

  logic [SLICE-1:0]  sp;
  logic [SLICE-1:0]  sg;
  logic [SLICE-1:0]  ss;
  logic              slice_co;

  assign sp = a_sh[SLICE-1:0] ^ b_sh[SLICE-1:0];
  assign sg = a_sh[SLICE-1:0] & b_sh[SLICE-1:0];

  // 4-bit lookahead groups; group carries chain from one group to the next
  for (genvar q = 0; q < NG; q++) begin : gen_grp
    logic       ci;
    logic [3:0] p4;
    logic [3:0] g4;
    logic [4:1] c;

    if (q == 0) begin : gen_first
      assign ci = carry_reg;
    end else begin : gen_next
      assign ci = gen_grp[q-1].c[4];
    end

    assign p4 = sp[4*q +: 4];
    assign g4 = sg[4*q +: 4];

    assign c[1] = g4[0] | (p4[0] & ci);
    assign c[2] = g4[1] | (p4[1] & g4[0]) | (p4[1] & p4[0] & ci);
    assign c[3] = g4[2] | (p4[2] & g4[1]) | (p4[2] & p4[1] & g4[0])
                | (p4[2] & p4[1] & p4[0] & ci);
    assign c[4] = g4[3] | (p4[3] & g4[2]) | (p4[3] & p4[2] & g4[1])
                | (p4[3] & p4[2] & p4[1] & g4[0]) | (&p4 & ci);

    assign ss[4*q +: 4] = p4 ^ {c[3:1], ci};
  end

  assign slice_co = gen_grp[NG-1].c[4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      k         <= '0;
      carry_reg <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      acc       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh      <= PW'(a);
            b_sh      <= PW'(b_in);
            carry_reg <= c_in;
            k         <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          a_sh      <= a_sh >> SLICE;
          b_sh      <= b_sh >> SLICE;
          acc       <= {ss, acc[PW-SLICE-1:SLICE]};
          carry_reg <= slice_co;
          k         <= k + KW'(1);
          if (k == KW'(NSLICE - 1)) begin
            // bit WIDTH of the padded sum is the carry out of bit WIDTH-1
            {cout, sum} <= (WIDTH + 1)'({slice_co, ss, acc});
            out_valid   <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_addsub_381bit.sv
// Directed and random checks for seq_addsub_381bit; subtract vectors run when SEQ_ADDSUB_SUB_EN is defined.
module tb_seq_addsub_381bit;
  localparam int W = 381;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
`ifdef SEQ_ADDSUB_SUB_EN
  logic         op;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_addsub_381bit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SEQ_ADDSUB_SUB_EN
    .op        (op),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // called at a negedge; returns at the negedge after the accepting edge
  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chkb("in_ready_before_accept", in_ready, 1'b1);
    a = av;
    b = bv;
    cin = cv;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 30);
  endtask

  task automatic release_result(input int stall);
    out_ready = 1'b0;
    repeat (stall) @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chkb("out_valid_drop", out_valid, 1'b0);
  endtask

  task automatic run_vec(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic cv, input logic [W:0] exp);
    int lat;
    start_op(av, bv, cv);
    wait_done(lat);
    chki({tag, "_lat"}, lat, 12);
    chk(tag, {cout, sum}, exp);
    release_result(0);
  endtask

  initial begin
    logic [W-1:0] ones;
    logic [W-1:0] t;
    logic [W-1:0] av;
    logic [W-1:0] bv;
    logic         cv;
    logic [W:0]   exp;
    logic [W:0]   held;
    int           lat;
    int           seen;

    ones      = {W{1'b1}};
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    a         = ones;
    b         = ones;
    cin       = 1'b1;
`ifdef SEQ_ADDSUB_SUB_EN
    op        = 1'b0;
`endif

    // reset held with in_valid asserted
    repeat (3) @(negedge clk);
    chkb("rst_in_ready", in_ready, 1'b1);
    chkb("rst_out_valid", out_valid, 1'b0);
    chkb("rst_busy", busy, 1'b0);
    chk("rst_sum_cout", {cout, sum}, '0);
    in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chkb("post_rst_busy", busy, 1'b0);

    // carry ripple through every slice
    start_op(ones, '0, 1'b1);
    chkb("run_busy", busy, 1'b1);
    chkb("run_in_ready", in_ready, 1'b0);
    wait_done(lat);
    chki("ripple_lat", lat, 12);
    chk("ripple", {cout, sum}, {1'b1, {W{1'b0}}});

    // backpressure in DONE with in_valid driven
    held = {cout, sum};
    in_valid = 1'b1;
    a = W'(123);
    b = W'(456);
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold", {cout, sum}, held);
      chkb("bp_in_ready", in_ready, 1'b0);
      chkb("bp_out_valid", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    chkb("bp_rel_out_valid", out_valid, 1'b0);
    chkb("bp_rel_in_ready", in_ready, 1'b1);
    chkb("bp_rel_busy", busy, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chkb("bp_no_capture", busy, 1'b0);

    // abort at k=5
    start_op({W{1'b1}} >> 7, W'(999), 1'b1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chkb("abort_in_ready", in_ready, 1'b1);
    chkb("abort_out_valid", out_valid, 1'b0);
    chkb("abort_busy", busy, 1'b0);
    chk("abort_sum_cout", {cout, sum}, '0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chki("abort_no_valid", seen, 0);
    run_vec("after_abort", W'(3), W'(4), 1'b0, (W + 1)'(7));

    // slice-boundary carries and top-bit carry out
    run_vec("slice0_carry", W'(32'hFFFF_FFFF), W'(1), 1'b0, (W + 1)'(1) << 32);
    run_vec("last_slice_entry", ({W{1'b1}} >> (W - 352)), '0, 1'b1, (W + 1)'(1) << 352);
    run_vec("top_bit", W'(1) << 380, W'(1) << 380, 1'b0, (W + 1)'(1) << 381);
    run_vec("all_ones", ones, ones, 1'b1, {1'b1, ones});
    run_vec("zero", '0, '0, 1'b0, '0);

`ifdef SEQ_ADDSUB_SUB_EN
    op = 1'b1;
    run_vec("sub_borrow", W'(5), W'(7), 1'b0, {1'b0, ones - W'(1)});
    run_vec("sub_noborrow", W'(7), W'(5), 1'b1, (W + 1)'(2) | ((W + 1)'(1) << W));
    op = 1'b0;
    run_vec("add_after_sub", W'(7), W'(5), 1'b1, (W + 1)'(13));
`endif

    // random operands with random result stalls
    t = '0;
    for (int i = 0; i < 1000; i++) begin
      for (int j = 0; j < 12; j++) t = {t[W-33:0], $urandom};
      av = t;
      for (int j = 0; j < 12; j++) t = {t[W-33:0], $urandom};
      bv = t;
      cv = 1'($urandom_range(0, 1));
      exp = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
      start_op(av, bv, cv);
      wait_done(lat);
      chki("rand_lat", lat, 12);
      chk("rand_sum", {cout, sum}, exp);
      release_result($urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
